// File: rtl/wptr_full_sync_if.sv
// Write-side bus of the async FIFO write-pointer block.
//   master : write-side user logic (drives wen, ovf_clr) plus read-domain rptr_gray
//   slave  : wptr_full_sync (drives address, Gray pointer, flags, level)
// Signals:
//   wen, ovf_clr         write request, overflow clear
//   rptr_gray            read pointer in Gray code, asynchronous to wclk
//   waddr                RAM write address
//   wptr_gray            registered Gray write pointer for the read domain
//   wfull, walmost_full  registered full / almost-full flags
//   wlevel               words held as seen from the write side
//   woverflow            sticky overflow flag
interface wptr_full_sync_if #(
  parameter int ASIZE = 4
);
  logic             wen;
  logic             ovf_clr;
  logic [ASIZE:0]   rptr_gray;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr_gray;
  logic             wfull;
  logic             walmost_full;
  logic [ASIZE:0]   wlevel;
  logic             woverflow;

  modport master (
    output wen, ovf_clr, rptr_gray,
    input  waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  wen, ovf_clr, rptr_gray,
    output waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_sync.sv
// Write-domain half of the async FIFO. Owns the binary and Gray write pointers,
// synchronises the read Gray pointer into wclk, and produces registered full,
// almost-full, fill level and a sticky overflow flag.
// Ports:
//   wclk   write clock
//   wrstn  asynchronous active-low reset
//   bus    wptr_full_sync_if.slave (wen, ovf_clr, rptr_gray in; waddr, wptr_gray,
//          wfull, walmost_full, wlevel, woverflow out)
module wptr_full_sync #(
  parameter int ASIZE        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input logic             wclk,
  input logic             wrstn,
  wptr_full_sync_if.slave bus
);
  localparam int             PW       = ASIZE + 1;
  localparam logic [ASIZE:0] LP_AFULL = PW'(AFULL_THRESH);

  logic [ASIZE:0]                  r_wbin;
  logic [ASIZE:0]                  r_wgray;
  logic [ASIZE:0]                  r_wlevel;
  logic                            r_wfull;
  logic                            r_afull;
  logic                            r_ovf;
  logic [SYNC_STAGES-1:0][ASIZE:0] r_sync;

  logic           w_wpush;
  logic [ASIZE:0] w_rq_gray;
  logic [ASIZE:0] w_rbin_s;
  logic [ASIZE:0] w_wbin_n;
  logic [ASIZE:0] w_wgray_n;
  logic [ASIZE:0] w_level_n;
  logic [ASIZE:0] w_full_gray;

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b        = '0;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // rptr_gray enters only the first stage; the last stage feeds the flag logic.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rptr_gray};
  end

  assign w_rq_gray = r_sync[SYNC_STAGES-1];
  assign w_rbin_s  = gray2bin(w_rq_gray);

  assign w_wpush   = bus.wen & ~r_wfull;
  assign w_wbin_n  = r_wbin + PW'(w_wpush);
  assign w_wgray_n = (w_wbin_n >> 1) ^ w_wbin_n;
  assign w_level_n = w_wbin_n - w_rbin_s;

  // Full in Gray space: the write pointer is one lap ahead of the read pointer,
  // which in Gray code means the top two bits inverted and the rest equal.
  assign w_full_gray = {~w_rq_gray[ASIZE:ASIZE-1], w_rq_gray[ASIZE-2:0]};

  // Flags use the next-state pointer so the filling write asserts wfull on its own edge.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      r_wbin   <= '0;
      r_wgray  <= '0;
      r_wlevel <= '0;
      r_wfull  <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_n;
      r_wgray  <= w_wgray_n;
      r_wlevel <= w_level_n;
      r_wfull  <= (w_wgray_n == w_full_gray);
      r_afull  <= (w_level_n >= LP_AFULL);
    end
  end

  // Set has priority over clear so a simultaneous overflow is never lost.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn)                   r_ovf <= 1'b0;
    else if (bus.wen & r_wfull)   r_ovf <= 1'b1;
    else if (bus.ovf_clr)         r_ovf <= 1'b0;
  end

  assign bus.waddr        = r_wbin[ASIZE-1:0];
  assign bus.wptr_gray    = r_wgray;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_afull;
  assign bus.wlevel       = r_wlevel;
  assign bus.woverflow    = r_ovf;
endmodule
